// File: rtl/sram_spi_pkg.sv
// Shared constants, frame layout and state encoding for the SRAM SPI master.
package sram_spi_pkg;

    localparam int FRAME_BITS = 32;
    localparam int ADDR_BITS  = 17;
    localparam int DATA_BITS  = 8;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Frame field positions, MSB first on the wire
    localparam int START_POS = 31;
    localparam int CMD_POS   = 30;
    localparam int ADDR_MSB  = 24;
    localparam int ADDR_LSB  = 8;
    localparam int DATA_MSB  = 7;
    localparam int DATA_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Assemble {1, cmd, 5'b0, addr, data}; reads carry a zero data byte
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 write,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] wdata
    );
        logic [FRAME_BITS-1:0] f;
        f                    = '0;
        f[START_POS]         = 1'b1;
        f[CMD_POS]           = write ? CMD_WRITE : CMD_READ;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = write ? wdata : '0;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: registered sclk that idles low, toggling every CLK_DIV
// clk cycles while enabled, with one-cycle strobes marking the clk edge on
// which sclk goes 0->1 (rise) or 1->0 (fall).
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_evt,
    output logic o_fall_evt
);

    logic [7:0] r_div;
    logic       r_sclk;
    logic       w_tick;

    assign w_tick     = i_en && (r_div == 8'(CLK_DIV - 1));
    assign o_rise_evt = w_tick && !r_sclk;
    assign o_fall_evt = w_tick && r_sclk;
    assign o_sclk     = r_sclk;

    // Half-period divider; disabling forces sclk low and restarts the count
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + 8'd1;
        end
    end

endmodule

// File: rtl/sram_spi_master.sv
// SPI master turning parallel SRAM requests into 32-bit frames for the
// CPLD SPI-to-SRAM bridge. One request per csn-low frame, mode 0, MSB first.
module sram_spi_master
    import sram_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CSN_SETUP = 4,
    parameter int unsigned CSN_HOLD  = 8,
    parameter int unsigned CSN_IDLE  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 sclk,
    output logic                 csn,
    output logic                 mosi,
    input  logic                 miso
);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [FRAME_BITS-2:0]   r_tx;      // bits still to send after the one on mosi
    logic [DATA_BITS-1:0]    r_rx;
    logic [5:0]              r_bitcnt;
    logic [7:0]              r_dly;
    logic                    r_write;
    logic                    r_mosi;
    logic                    r_csn;
    logic                    r_ready;
    logic                    r_busy;
    logic                    r_rsp_valid;
    logic [DATA_BITS-1:0]    r_rdata;

    logic [FRAME_BITS-1:0]   w_frame;
    logic                    w_accept;
    logic                    w_shift_en;
    logic                    w_rise;
    logic                    w_fall;
    logic                    w_last_fall;
    logic                    w_csn_nxt;
    logic                    w_ready_nxt;
    logic                    w_busy_nxt;
    logic                    w_rsp_nxt;

    assign w_frame     = build_frame(req_write, req_addr, req_wdata);
    assign w_accept    = req_valid && r_ready;
    assign w_shift_en  = (r_state == ST_SHIFT);
    assign w_last_fall = w_fall && (r_bitcnt == 6'(FRAME_BITS));

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (w_shift_en),
        .o_sclk     (sclk),
        .o_rise_evt (w_rise),
        .o_fall_evt (w_fall)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept)                        w_state_nxt = ST_SETUP;
            ST_SETUP: if (r_dly == 8'(CSN_SETUP - 1))      w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last_fall)                     w_state_nxt = ST_HOLD;
            ST_HOLD:  if (r_dly == 8'(CSN_HOLD - 1))       w_state_nxt = ST_GAP;
            ST_GAP:   if (r_dly == 8'(CSN_IDLE - 1))       w_state_nxt = ST_IDLE;
            default:                                       w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the pins can be registered
    always_comb begin
        w_csn_nxt   = 1'b1;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        unique case (w_state_nxt)
            ST_IDLE: begin
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
            ST_SETUP, ST_SHIFT, ST_HOLD: w_csn_nxt = 1'b0;
            default: w_csn_nxt = 1'b1;
        endcase
        w_rsp_nxt = (r_state == ST_HOLD) && (w_state_nxt == ST_GAP);
    end

    // Registered handshake and chip-select outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csn       <= 1'b1;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_csn       <= w_csn_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_rsp_valid <= w_rsp_nxt;
        end
    end

    // Frame shifter, miso capture, bit/delay counters and response data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx     <= '0;
            r_rx     <= '0;
            r_mosi   <= 1'b0;
            r_bitcnt <= '0;
            r_dly    <= '0;
            r_write  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
                r_dly <= '0;
            end else begin
                r_dly <= r_dly + 8'd1;
            end

            if (w_accept) begin
                r_tx     <= w_frame[FRAME_BITS-2:0];
                r_mosi   <= w_frame[START_POS];
                r_bitcnt <= '0;
                r_write  <= req_write;
            end else if (w_rise) begin
                r_rx     <= {r_rx[DATA_BITS-2:0], miso};
                r_bitcnt <= r_bitcnt + 6'd1;
            end else if (w_fall && !w_last_fall) begin
                r_mosi   <= r_tx[FRAME_BITS-2];
                r_tx     <= {r_tx[FRAME_BITS-3:0], 1'b0};
            end

            // The rx register holds the last eight sampled bits, i.e. rises 25..32
            if (w_rsp_nxt) begin
                r_rdata <= r_write ? '0 : r_rx;
                r_mosi  <= 1'b0;
            end
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign csn       = r_csn;
    assign mosi      = r_mosi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_sram_spi_master.sv
// Directed bench for sram_spi_master: two instances (CLK_DIV=2 and 255) with
// a small bridge model on each that records mosi and drives miso.
module tb_sram_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A, CLK_DIV = 2
    logic        a_valid = 1'b0, a_write = 1'b0, a_miso = 1'b0;
    logic [16:0] a_addr  = '0;
    logic [7:0]  a_wdata = '0;
    logic        a_ready, a_rsp_valid, a_busy, a_sclk, a_csn, a_mosi;
    logic [7:0]  a_rdata;

    // Instance B, CLK_DIV = 255
    logic        b_valid = 1'b0, b_write = 1'b0, b_miso = 1'b0;
    logic [16:0] b_addr  = '0;
    logic [7:0]  b_wdata = '0;
    logic        b_ready, b_rsp_valid, b_busy, b_sclk, b_csn, b_mosi;
    logic [7:0]  b_rdata;

    sram_spi_master #(.CLK_DIV(2), .CSN_SETUP(4), .CSN_HOLD(8), .CSN_IDLE(4)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .busy(a_busy),
        .sclk(a_sclk), .csn(a_csn), .mosi(a_mosi), .miso(a_miso)
    );

    sram_spi_master #(.CLK_DIV(255), .CSN_SETUP(4), .CSN_HOLD(8), .CSN_IDLE(4)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .busy(b_busy),
        .sclk(b_sclk), .csn(b_csn), .mosi(b_mosi), .miso(b_miso)
    );

    // Bridge model A: capture mosi on sclk rises, shift a miso pattern out MSB first
    logic [31:0] a_pat = '0, a_sh = '0, a_txcap = '0;
    int          a_rises = 0, a_rsp_cnt = 0;
    logic        a_prev_csn = 1'b1, a_prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (!a_csn && a_prev_csn) begin
            a_rises = 0;
            a_txcap = '0;
            a_sh    = a_pat;
            a_miso  = a_sh[31];
        end
        if (a_sclk && !a_prev_sclk && !a_csn) begin
            a_txcap = {a_txcap[30:0], a_mosi};
            a_rises++;
            a_sh    = a_sh << 1;
            a_miso  = a_sh[31];
        end
        if (a_rsp_valid) a_rsp_cnt++;
        a_prev_csn  = a_csn;
        a_prev_sclk = a_sclk;
    end

    // Bridge model B: alternating miso starting at 1, plus sclk phase length checks
    logic [31:0] b_txcap = '0;
    int          b_run = 0, b_hi_runs = 0, b_hi_bad = 0, b_lo_bad = 0;
    bit          b_seen_fall = 1'b0;
    logic        b_prev_csn = 1'b1, b_prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (!b_csn && b_prev_csn) begin
            b_txcap     = '0;
            b_miso      = 1'b1;
            b_seen_fall = 1'b0;
            b_hi_runs   = 0;
        end
        if (b_sclk != b_prev_sclk) begin
            if (b_sclk) begin
                b_txcap = {b_txcap[30:0], b_mosi};
                b_miso  = ~b_miso;
                if (b_seen_fall && b_run != 255) b_lo_bad++;
            end else begin
                b_hi_runs++;
                if (b_run != 255) b_hi_bad++;
                b_seen_fall = 1'b1;
            end
            b_run = 1;
        end else begin
            b_run++;
        end
        b_prev_csn  = b_csn;
        b_prev_sclk = b_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request on A; lat = cycles from the accept cycle to rsp_valid
    task automatic a_xfer(input logic wr, input logic [16:0] addr, input logic [7:0] wd,
                          input logic [31:0] pat, input bit hold, input bit corrupt,
                          output int lat);
        int n;
        @(negedge clk);
        a_pat   = pat;
        a_write = wr;
        a_addr  = addr;
        a_wdata = wd;
        a_valid = 1'b1;
        n = 0;
        while (!a_ready && n < 200) begin @(negedge clk); n++; end
        lat = 0;
        @(negedge clk);
        lat = 1;
        if (!hold) a_valid = 1'b0;
        if (corrupt) a_wdata = ~wd;
        while (!a_rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
    endtask

    initial begin
        int lat, n, csn_hi, rdy_hi, rsp_before;

        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_csn",       32'(a_csn), 32'd1);
        chk("rst_sclk",      32'(a_sclk), 32'd0);
        chk("rst_mosi",      32'(a_mosi), 32'd0);
        chk("rst_ready",     32'(a_ready), 32'd0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rdata",     32'(a_rdata), 32'd0);
        chk("rst_busy",      32'(a_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(a_ready), 32'd1);
        chk("busy_after_rst",  32'(a_busy), 32'd0);

        // Write; wdata is altered right after the handshake
        a_xfer(1'b1, 17'h1ABCD, 8'h5A, 32'hFFFF_FFFF, 1'b0, 1'b1, lat);
        chk("wr_latency", lat, 32'd141);
        chk("wr_frame",   a_txcap, 32'hC1AB_CD5A);
        chk("wr_rises",   a_rises, 32'd32);
        chk("wr_rdata",   32'(a_rdata), 32'd0);
        chk("wr_csn_end", 32'(a_csn), 32'd1);

        // Read returning A5 in the last byte
        a_xfer(1'b0, 17'h00010, 8'hFF, 32'h0000_00A5, 1'b0, 1'b0, lat);
        chk("rd_latency", lat, 32'd141);
        chk("rd_frame",   a_txcap, 32'h8000_1000);
        chk("rd_rdata",   32'(a_rdata), 32'hA5);
        @(negedge clk);
        chk("rd_pulse",   32'(a_rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("rd_hold",    32'(a_rdata), 32'hA5);

        // Back-to-back with req_valid held high
        a_xfer(1'b1, 17'h0_0001, 8'h11, 32'h0, 1'b1, 1'b0, lat);
        a_addr  = 17'h10155;
        a_wdata = 8'h96;
        csn_hi = 0; rdy_hi = 0; n = 0;
        while (a_csn && n < 100) begin
            csn_hi++;
            if (a_ready) rdy_hi++;
            @(negedge clk);
            n++;
        end
        a_valid = 1'b0;
        chk("b2b_csn_high", csn_hi, 32'd5);
        chk("b2b_ready",    rdy_hi, 32'd1);
        lat = 1;
        while (!a_rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
        chk("b2b_latency",  lat, 32'd141);
        chk("b2b_frame",    a_txcap, 32'hC101_5596);

        // Reset in the middle of a write, at bit 17
        @(negedge clk);
        a_write = 1'b1; a_addr = 17'h0F0F0; a_wdata = 8'hC3; a_valid = 1'b1;
        n = 0;
        while (!a_ready && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        a_valid = 1'b0;
        rsp_before = a_rsp_cnt;
        n = 0;
        while (a_rises != 17 && n < 1000) begin @(negedge clk); n++; end
        chk("abort_sclk_pre", 32'(a_sclk), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_csn",  32'(a_csn), 32'd1);
        chk("abort_sclk", 32'(a_sclk), 32'd0);
        chk("abort_mosi", 32'(a_mosi), 32'd0);
        chk("abort_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_no_rsp", a_rsp_cnt, rsp_before);
        a_xfer(1'b1, 17'h0F0F0, 8'hC3, 32'h0, 1'b0, 1'b0, lat);
        chk("retry_latency", lat, 32'd141);
        chk("retry_frame",   a_txcap, 32'hC0F0_F0C3);

        // Slowest divider on B, miso alternating 1/0
        @(negedge clk);
        b_write = 1'b0; b_addr = 17'h1FFFF; b_valid = 1'b1;
        n = 0;
        while (!b_ready && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        lat = 1;
        b_valid = 1'b0;
        while (!b_rsp_valid && lat < 20000) begin @(negedge clk); lat++; end
        chk("slow_latency", lat, 32'd16333);
        chk("slow_rdata",   32'(b_rdata), 32'hAA);
        chk("slow_frame",   b_txcap, 32'h81FF_FF00);
        chk("slow_hi_runs", b_hi_runs, 32'd32);
        chk("slow_hi_len",  b_hi_bad, 32'd0);
        chk("slow_lo_len",  b_lo_bad, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
